pulse_div_sel: RTL

//  - Parametrised clock-enable divider with four selectable output rates, run enable and single-cycle tick.
//  - Drives the slow clock and strobe for display/counter logic (e.g. the up/down counter at 1/2/5/50 Hz).
//  - Mode changes restart the count cleanly: the count never runs past the terminal value.
//  - Outputs are registers in the I_CLK domain. Downstream logic uses O_TICK as an enable and does not use O_CLK as a clock.

---
 rtl/pulse_div_sel_if.sv | 25 ++
 rtl/pulse_div_sel.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pulse_div_sel_if.sv
// Control/status bundle for pulse_div_sel: run enable and rate select in,
// divided clock, tick strobe and active select out.
interface pulse_div_sel_if;
    logic       I_EN;
    logic [1:0] I_SEL;
    logic       O_CLK;
    logic       O_TICK;
    logic [1:0] O_SEL;

    modport master (
        output I_EN,
        output I_SEL,
        input  O_CLK,
        input  O_TICK,
        input  O_SEL
    );

    modport slave (
        input  I_EN,
        input  I_SEL,
        output O_CLK,
        output O_TICK,
        output O_SEL
    );
endinterface

// File: rtl/pulse_div_sel.sv
// Clock-enable divider with four selectable half-periods, run enable and a tick strobe.
// Define PULSE_DIV_SEL_GLITCHLESS_EN to defer rate changes to the next O_CLK falling toggle.
module pulse_div_sel #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned HALF0 = 25_000_000,
    parameter int unsigned HALF1 = 12_500_000,
    parameter int unsigned HALF2 = 5_000_000,
    parameter int unsigned HALF3 = 500_000
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    pulse_div_sel_if.slave   bus
);

    // Terminal counts (H-1); a half-period of 0 behaves as 1.
    localparam logic [CNT_W-1:0] HM1_0 = (HALF0 > 1) ? CNT_W'(HALF0 - 1) : '0;
    localparam logic [CNT_W-1:0] HM1_1 = (HALF1 > 1) ? CNT_W'(HALF1 - 1) : '0;
    localparam logic [CNT_W-1:0] HM1_2 = (HALF2 > 1) ? CNT_W'(HALF2 - 1) : '0;
    localparam logic [CNT_W-1:0] HM1_3 = (HALF3 > 1) ? CNT_W'(HALF3 - 1) : '0;

`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_q,   clk_d;
    logic             tick_q,  tick_d;
    logic [1:0]       sel_q,   sel_d;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
    logic [1:0]       pend_q,  pend_d;
`endif

    logic [CNT_W-1:0] half_m1;
    logic             wrap;
    logic [CNT_W-1:0] count_adv;
    logic             clk_adv;

    // Terminal count for the rate currently in effect.
    always_comb begin
        half_m1 = HM1_0;
        case (sel_q)
            2'd0:    half_m1 = HM1_0;
            2'd1:    half_m1 = HM1_1;
            2'd2:    half_m1 = HM1_2;
            default: half_m1 = HM1_3;
        endcase
    end

    // ">=" guards against a count left above the terminal value by a rate change.
    always_comb begin
        wrap      = (count_q >= half_m1);
        count_adv = wrap ? '0 : count_q + CNT_W'(1);
        clk_adv   = wrap ? ~clk_q : clk_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        sel_d   = sel_q;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
        pend_d  = pend_q;
`endif

        case (state_q)
            ST_STOP: begin
                count_d = '0;
                clk_d   = 1'b0;
                sel_d   = bus.I_SEL;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
                pend_d  = bus.I_SEL;
`endif
                if (bus.I_EN) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                if (!bus.I_EN) begin
                    state_d = ST_STOP;
                    count_d = '0;
                    clk_d   = 1'b0;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
                    sel_d   = (state_q == ST_PEND) ? pend_q : bus.I_SEL;
                    pend_d  = sel_d;
`else
                    sel_d   = bus.I_SEL;
`endif
                end else begin
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
                    // Old rate keeps running; a new select lands only on a 1->0 toggle.
                    count_d = count_adv;
                    clk_d   = clk_adv;
                    tick_d  = wrap & ~clk_q;
                    state_d = ST_RUN;
                    if (bus.I_SEL != sel_q) begin
                        if (wrap && clk_q) begin
                            sel_d = bus.I_SEL;
                        end else begin
                            state_d = ST_PEND;
                            pend_d  = bus.I_SEL;
                        end
                    end
`else
                    // Rate change restarts the current phase at the new rate.
                    if (bus.I_SEL != sel_q) begin
                        sel_d   = bus.I_SEL;
                        count_d = '0;
                    end else begin
                        count_d = count_adv;
                        clk_d   = clk_adv;
                        tick_d  = wrap & ~clk_q;
                    end
`endif
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q <= ST_STOP;
            count_q <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            sel_q   <= 2'd0;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
            pend_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            sel_q   <= sel_d;
`ifdef PULSE_DIV_SEL_GLITCHLESS_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign bus.O_CLK  = clk_q;
    assign bus.O_TICK = tick_q;
    assign bus.O_SEL  = sel_q;

endmodule
